// File: rtl/vending_machine_param.sv
// Parameterised vending machine: coin accumulation, priced/stocked items and greedy coin return.
// Defining TIMEOUT_EN builds an inactivity counter that forces a return after WAIT_TIME idle cycles.
module vending_machine_param #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned NUM_COINS  = 3,
    parameter int unsigned TOTAL_BITS = 16,
    parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
    parameter logic [NUM_ITEMS*TOTAL_BITS-1:0] ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400},
    parameter int unsigned STOCK_BITS = 4,
    parameter int unsigned INIT_STOCK = 15,
    parameter int unsigned WAIT_TIME  = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic                  i_restock,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [TOTAL_BITS-1:0] o_current_total,
    output logic                  o_coin_reject
);

    localparam int unsigned SUM_W = TOTAL_BITS + NUM_COINS;
    localparam logic [SUM_W-1:0] TOTAL_MAX = {{NUM_COINS{1'b0}}, {TOTAL_BITS{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETURN} state_t;

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [STOCK_BITS-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_BITS-1:0] stock_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0]  item_q, item_d;
    logic [NUM_COINS-1:0]  ret_q, ret_d;
    logic                  reject_q, reject_d;

    logic [NUM_ITEMS-1:0]  avail, sel_oh, buy_oh;
    logic [SUM_W-1:0]      coin_sum;
    logic                  coin_ok;
    logic [TOTAL_BITS-1:0] add_val, price_val, ret_val;
    logic [NUM_COINS-1:0]  ret_oh;
    logic                  timeout;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int idx);
        return COIN_VALUES[idx*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    function automatic logic [TOTAL_BITS-1:0] item_price(input int idx);
        return ITEM_PRICES[idx*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    always_comb begin
        avail = '0;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            avail[i] = (total_q >= item_price(i)) && (stock_q[i] != '0) && (state_q != S_RETURN);
        end
    end

    assign o_available_item = avail;

    // Per-cycle arithmetic: coin sum with overflow guard, lowest-index purchase, greedy change pick.
    always_comb begin
        coin_sum  = '0;
        price_val = '0;
        ret_oh    = '0;
        ret_val   = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (i_input_coin[i]) begin
                coin_sum = coin_sum + SUM_W'(coin_value(i));
            end
        end
        coin_ok = (SUM_W'(total_q) + coin_sum) <= TOTAL_MAX;
        add_val = coin_ok ? coin_sum[TOTAL_BITS-1:0] : '0;

        sel_oh = i_select_item & (~i_select_item + NUM_ITEMS'(1));
        buy_oh = sel_oh & avail;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            if (buy_oh[i]) begin
                price_val = item_price(i);
            end
        end

        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (coin_value(i) <= total_q) begin
                ret_oh    = '0;
                ret_oh[i] = 1'b1;
                ret_val   = coin_value(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        stock_d  = stock_q;
        item_d   = '0;
        ret_d    = '0;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE, S_ACTIVE: begin
                reject_d = (i_input_coin != '0) && !coin_ok;
                item_d   = buy_oh;
                total_d  = total_q + add_val - price_val;
                for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                    if (buy_oh[i]) begin
                        stock_d[i] = stock_q[i] - STOCK_BITS'(1);
                    end
                end
                if ((state_q == S_ACTIVE) && (i_trigger_return || timeout)) begin
                    state_d = S_RETURN;
                end else begin
                    state_d = (total_d != '0) ? S_ACTIVE : S_IDLE;
                end
            end
            S_RETURN: begin
                reject_d = (i_input_coin != '0);
                if (total_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ret_d   = ret_oh;
                    // A residue smaller than every coin cannot be paid out and is dropped.
                    total_d = (ret_oh == '0) ? '0 : (total_q - ret_val);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_restock) begin
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock_d[i] = STOCK_BITS'(INIT_STOCK);
            end
        end
    end

`ifdef TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_TIME + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             activity;

    assign activity = (i_input_coin != '0) || (i_select_item != '0);
    assign timeout  = (state_q == S_ACTIVE) && !activity && (cnt_q == CNT_W'(WAIT_TIME - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (activity || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q == S_ACTIVE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            total_q  <= '0;
            item_q   <= '0;
            ret_q    <= '0;
            reject_q <= 1'b0;
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock_q[i] <= STOCK_BITS'(INIT_STOCK);
            end
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            item_q   <= item_d;
            ret_q    <= ret_d;
            reject_q <= reject_d;
            stock_q  <= stock_d;
        end
    end

    assign o_output_item   = item_q;
    assign o_return_coin   = ret_q;
    assign o_current_total = total_q;
    assign o_coin_reject   = reject_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Randomised bench for vending_machine_param with a balance/stock reference model and literal pins.
module tb_vending_machine_param;

    localparam int NI   = 4;
    localparam int NC   = 3;
    localparam int INIT = 2;
    localparam int WT   = 100;
    localparam int MAXT = 65535;

    int coin_val [NC] = '{100, 500, 1000};
    int price    [NI] = '{400, 500, 1000, 2000};

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] i_input_coin;
    logic [NI-1:0] i_select_item;
    logic          i_trigger_return;
    logic          i_restock;
    logic [NI-1:0] o_available_item;
    logic [NI-1:0] o_output_item;
    logic [NC-1:0] o_return_coin;
    logic [15:0]   o_current_total;
    logic          o_coin_reject;

    vending_machine_param #(.INIT_STOCK(INIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_restock        (i_restock),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_current_total  (o_current_total),
        .o_coin_reject    (o_coin_reject)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: balance, stock per item, returning flag, quiet-cycle run length.
    int            m_tot;
    int            m_stk [NI];
    bit            m_ret;
    int            m_run;
    logic [NI-1:0] e_item;
    logic [NC-1:0] e_rc;
    logic          e_rej;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NI-1:0] m_avail();
        logic [NI-1:0] a;
        a = '0;
        for (int k = 0; k < NI; k++) a[k] = !m_ret && (m_tot >= price[k]) && (m_stk[k] != 0);
        return a;
    endfunction

    task automatic model_reset();
        m_tot = 0; m_ret = 0; m_run = 0;
        for (int k = 0; k < NI; k++) m_stk[k] = INIT;
        e_item = '0; e_rc = '0; e_rej = 1'b0;
    endtask

    task automatic model_step(input logic [NC-1:0] c, input logic [NI-1:0] s, input logic t, input logic r);
        int csum, ntot, add, pr, j;
        logic [NI-1:0] av;
        bit active, quiet, tmo, go_ret, nact;
        av = m_avail();
        e_item = '0; e_rc = '0; e_rej = 1'b0;
        if (m_ret) begin
            e_rej = (c != 0);
            if (m_tot == 0) m_ret = 0;
            else begin
                j = -1;
                for (int k = 0; k < NC; k++) if (coin_val[k] <= m_tot) j = k;
                if (j < 0) m_tot = 0;
                else begin e_rc[j] = 1'b1; m_tot -= coin_val[j]; end
            end
            m_run = 0;
        end else begin
            active = m_tot > 0;
            quiet  = (c == 0) && (s == 0);
            csum = 0;
            for (int k = 0; k < NC; k++) if (c[k]) csum += coin_val[k];
            add = 0;
            if (c != 0) begin
                if (m_tot + csum > MAXT) e_rej = 1'b1;
                else add = csum;
            end
            pr = 0; j = -1;
            for (int k = NI - 1; k >= 0; k--) if (s[k]) j = k;
            if (j >= 0 && av[j]) begin e_item[j] = 1'b1; pr = price[j]; m_stk[j]--; end
            ntot = m_tot + add - pr;
            tmo = 0;
`ifdef TIMEOUT_EN
            tmo = active && quiet && (m_run + 1 == WT);
`endif
            go_ret = active && (t || tmo);
            nact   = !go_ret && (ntot > 0);
            if (!quiet || go_ret || (nact != active)) m_run = 0;
            else if (active) m_run++;
            m_tot = ntot;
            m_ret = go_ret;
        end
        if (r) for (int k = 0; k < NI; k++) m_stk[k] = INIT;
    endtask

    // Advance the model on every edge and compare all outputs just after it.
    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step(i_input_coin, i_select_item, i_trigger_return, i_restock);
        #1;
        check("total", 32'(o_current_total), 32'(m_tot));
        check("avail", 32'(o_available_item), 32'(m_avail()));
        check("item",  32'(o_output_item), 32'(e_item));
        check("retcoin", 32'(o_return_coin), 32'(e_rc));
        check("reject", 32'(o_coin_reject), 32'(e_rej));
    end

    task automatic drive(input logic [NC-1:0] c, input logic [NI-1:0] s, input logic t, input logic r);
        @(negedge clk);
        reset = 1'b0; i_input_coin = c; i_select_item = s; i_trigger_return = t; i_restock = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0; i_restock = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int found;
        reset = 1'b1; i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0; i_restock = 1'b0;
        repeat (2) @(negedge clk);
        check("pin_reset_total", 32'(o_current_total), 32'd0);
        check("pin_reset_avail", 32'(o_available_item), 32'd0);
        reset = 1'b0;

        repeat (4) drive(3'b001, 4'b0000, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_total_400", 32'(o_current_total), 32'd400);
        check("pin_avail_400", 32'(o_available_item), 32'b0001);
        drive(3'b100, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_total_1400", 32'(o_current_total), 32'd1400);
        check("pin_avail_1400", 32'(o_available_item), 32'b0111);
        drive('0, 4'b1000, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_no_buy_item", 32'(o_output_item), 32'd0);
        check("pin_no_buy_total", 32'(o_current_total), 32'd1400);
        drive('0, 4'b0001, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_buy0_item", 32'(o_output_item), 32'b0001);
        check("pin_buy0_total", 32'(o_current_total), 32'd1000);
        drive(3'b011, '0, 1'b0, 1'b0);
        drive(3'b001, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_total_1700", 32'(o_current_total), 32'd1700);
        drive('0, '0, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_ret_avail", 32'(o_available_item), 32'd0);
        drive(3'b001, '0, 1'b0, 1'b0);
        check("pin_ret1", 32'(o_return_coin), 32'b100);
        check("pin_ret1_total", 32'(o_current_total), 32'd700);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_ret2", 32'(o_return_coin), 32'b010);
        check("pin_ret_reject", 32'(o_coin_reject), 32'd1);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_ret3", 32'(o_return_coin), 32'b001);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_ret4", 32'(o_return_coin), 32'b001);
        check("pin_ret_total0", 32'(o_current_total), 32'd0);
        drive('0, '0, 1'b1, 1'b0);
        repeat (3) drive('0, '0, 1'b0, 1'b0);

        do_reset();
        repeat (5) drive(3'b100, '0, 1'b0, 1'b0);
        drive(3'b010, '0, 1'b0, 1'b0);
        drive('0, 4'b0001, 1'b0, 1'b0);
        drive('0, 4'b0001, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_stock_total", 32'(o_current_total), 32'd4700);
        check("pin_stock_empty", 32'(o_available_item), 32'b1110);
        drive('0, 4'b0001, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_empty_nobuy", 32'(o_output_item), 32'd0);
        drive('0, '0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_restock", 32'(o_available_item), 32'b1111);
        drive('0, 4'b0001, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_restock_buy_total", 32'(o_current_total), 32'd4300);
        check("pin_restock_prio", 32'(o_available_item), 32'b1111);

        do_reset();
        repeat (4) drive(3'b001, '0, 1'b0, 1'b0);
        drive(3'b100, 4'b0010, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_pre_edge_item", 32'(o_output_item), 32'd0);
        check("pin_pre_edge_total", 32'(o_current_total), 32'd1400);
        drive(3'b001, 4'b0101, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_coin_sel_item", 32'(o_output_item), 32'b0001);
        check("pin_coin_sel_total", 32'(o_current_total), 32'd1100);
        drive('0, 4'b0001, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_sel_trig_item", 32'(o_output_item), 32'b0001);
        check("pin_sel_trig_total", 32'(o_current_total), 32'd700);
        repeat (6) drive('0, '0, 1'b0, 1'b0);
        check("pin_drained", 32'(o_current_total), 32'd0);

        do_reset();
        repeat (40) drive(3'b111, '0, 1'b0, 1'b0);
        drive(3'b100, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_total_65000", 32'(o_current_total), 32'd65000);
        drive(3'b100, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_ovf_reject", 32'(o_coin_reject), 32'd1);
        check("pin_ovf_total", 32'(o_current_total), 32'd65000);
        drive(3'b010, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        check("pin_65500_reject", 32'(o_coin_reject), 32'd0);
        check("pin_65500_total", 32'(o_current_total), 32'd65500);
        drive('0, '0, 1'b1, 1'b0);
        do_reset();

        drive(3'b010, '0, 1'b0, 1'b0);
        found = -1;
        for (int k = 1; k <= 150 && found < 0; k++) begin
            drive('0, '0, 1'b0, 1'b0);
            if (o_return_coin != '0) begin
                found = k;
                check("pin_timeout_coin", 32'(o_return_coin), 32'b010);
                check("pin_timeout_total", 32'(o_current_total), 32'd0);
            end
        end
`ifdef TIMEOUT_EN
        check("pin_timeout_cycle", 32'(found), 32'd102);
`else
        check("pin_no_timeout", 32'(found), 32'hFFFF_FFFF);
        check("pin_no_timeout_total", 32'(o_current_total), 32'd500);
`endif

        for (int n = 0; n < 4000; n++) begin
            logic [NC-1:0] c;
            logic [NI-1:0] s;
            c = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
            s = ($urandom_range(0, 4) == 0) ? NI'($urandom) : '0;
            if ($urandom_range(0, 600) == 0) do_reset();
            else if ($urandom_range(0, 300) == 0) repeat (WT + 10) drive('0, '0, 1'b0, 1'b0);
            else drive(c, s, $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0);
        end
        repeat (20) drive('0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
